// File: rtl/spi_slave_rx_tx.sv
`timescale 1ns/1ps
// spi_slave_rx_tx
// SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave endpoint. The serial lines are
// oversampled in the local clk domain through SYNC_STAGES flops each. The slave
// deserialises mosi into rx_data and hands it over with valid/ready. It also
// serialises a preloaded holding register onto miso.
//
// Optional build macro: SPI_SLAVE_OVERRUN_EN adds the sticky rx_overrun output.
//
// Ports:
//   clk, reset          system clock (>= 8x sclk) and async active-high reset
//   ss, sclk, mosi      SPI lines from the master (ss active-high)
//   miso, miso_oe       serial data to the master and its output enable
//   tx_data, tx_load    word to transmit and its capture strobe
//   tx_empty            holding register consumed by a frame start
//   rx_data, rx_valid   last received word and its valid flag
//   rx_ready            consumer accept
//   busy                frame in progress (FSM not idle)
//   frame_err           one-cycle pulse when ss drops mid-frame
//   rx_overrun          (SPI_SLAVE_OVERRUN_EN only) unread word overwritten
//   state_dbg           current FSM state encoding
//
// Handshake: a word transfers on every clk cycle where rx_valid & rx_ready.
// rx_valid then drops on the next cycle unless a new word lands in that cycle.
// A new word landing while rx_valid=1 and rx_ready=0 overwrites the old word.
module spi_slave_rx_tx #(
  parameter int DWIDTH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              frame_err,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic              rx_overrun,
`endif
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(DWIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DWIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, next_state;

  // Synchronisers; the last stage is the only copy that logic looks at.
  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, sclk_s, mosi_s;
  logic ss_d, sclk_d;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic ss_rise, sclk_rise, sclk_fall;
  assign ss_rise   = ss_s & ~ss_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  // Datapath registers
  logic [DWIDTH-1:0] hold;
  logic [DWIDTH-1:0] tx_shift;
  logic [DWIDTH-1:0] rx_shift;
  logic [CW-1:0]     bit_cnt;
  // Set by a back-to-back reload: the next falling edge presents the new MSB
  // instead of shifting, since the master has not yet sampled it.
  logic              reload_pend;

  // Control strobes from the FSM
  logic start, rx_step, tx_step, reload, abort, err, to_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    rx_step    = 1'b0;
    tx_step    = 1'b0;
    reload     = 1'b0;
    abort      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (ss_rise) begin
          start      = 1'b1;
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        // Deselect wins over any simultaneous clock edge.
        if (!ss_s) begin
          abort      = 1'b1;
          err        = (bit_cnt != '0);
          next_state = IDLE;
        end else if (sclk_rise) begin
          rx_step = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = DONE;
        end else if (sclk_fall && (bit_cnt < FULL_CNT)) begin
          tx_step = 1'b1;
        end
      end
      DONE: begin
        if (ss_s) begin
          reload     = 1'b1;
          next_state = ACTIVE;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign to_idle   = (state != IDLE) && (next_state == IDLE);
  assign busy      = (state != IDLE);
  assign miso_oe   = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold        <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      miso        <= 1'b0;
      tx_empty    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= err;

      if (start) begin
        tx_shift    <= hold;
        miso        <= hold[DWIDTH-1];
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end

      if (rx_step) begin
        rx_shift <= {rx_shift[DWIDTH-2:0], mosi_s};
        bit_cnt  <= bit_cnt + 1'b1;
      end

      if (tx_step) begin
        if (reload_pend) begin
          miso        <= tx_shift[DWIDTH-1];
          reload_pend <= 1'b0;
        end else begin
          tx_shift <= tx_shift << 1;
          miso     <= tx_shift[DWIDTH-2];
        end
      end

      if (abort) begin
        rx_shift    <= '0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end

      if (to_idle) miso <= 1'b0;

      if (reload) begin
        tx_shift    <= hold;
        bit_cnt     <= '0;
        reload_pend <= 1'b1;
      end

      // Frame start consumes the holding register; a load in the same cycle
      // lands afterwards and stays pending.
      if (start || reload) tx_empty <= 1'b1;
      if (tx_load) begin
        hold     <= tx_data;
        tx_empty <= 1'b0;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (state == DONE) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun <= 1'b0;
    end else if (rx_valid && rx_ready) begin
      rx_overrun <= 1'b0;
    end else if ((state == DONE) && rx_valid) begin
      rx_overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave_rx_tx (DWIDTH=8, SYNC_STAGES=2).
// A bit-level SPI master drives sclk at clk/8 and records miso on each rising
// edge. Expected words come from a small model of the holding register and
// from the words the master sent.
module tb_spi_slave_rx_tx;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ss = 1'b0, sclk = 1'b0, mosi = 1'b0;
  logic          miso, miso_oe;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0;
  logic          tx_empty;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          busy, frame_err;
  logic [1:0]    state_dbg;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic          rx_overrun;
`endif

  spi_slave_rx_tx #(.DWIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ss(ss), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_overrun(rx_overrun),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Scoreboard: words accepted by the consumer, frame_err pulses, busy gaps
  logic [DW-1:0] got_q[$];
  int err_cnt   = 0;
  int busy_gap  = 0;
  logic in_burst = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) err_cnt++;
      if (in_burst && !busy) busy_gap++;
    end
  end

  // Reference model of the transmit side and last received word
  logic [DW-1:0] m_hold = '0;
  logic [DW-1:0] m_last_rx = '0;

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [DW-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    m_hold  = v;
  endtask

  task automatic ss_on();
    ss = 1'b1;
    tick(3);
  endtask

  task automatic ss_off();
    ss   = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(8);
  endtask

  // One frame of nbits, MSB first; miso sampled at each rising edge.
  task automatic xfer(input logic [DW-1:0] w, input int nbits, output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[DW-1-i];
      tick(4);
      sclk = 1'b1;
      got = {got[DW-2:0], miso};
      tick(4);
      sclk = 1'b0;
    end
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    total_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else pass_cnt++;
    total_cnt++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b want 0", miso_oe); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL reset_tx_empty: got %b want 1", tx_empty); else pass_cnt++;
    total_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else pass_cnt++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    logic [DW-1:0] g;
    int e0;
    e0 = err_cnt;
    rx_ready = 1'b0;
    do_load(8'hA5);
    ss_on();
    xfer(8'h3C, 8, g);
    ss_off();
    m_last_rx = 8'h3C;
    total_cnt++; if (g !== 8'hA5) $display("FAIL basic_miso: got %h want a5", g); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h3C) $display("FAIL basic_rx_data: got %h want 3c", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL basic_rx_valid: got %b want 1", rx_valid); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL basic_tx_empty: got %b want 1", tx_empty); else pass_cnt++;
    total_cnt++; if (err_cnt !== e0) $display("FAIL basic_frame_err: got %0d pulses want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (miso_oe !== 1'b0) $display("FAIL basic_idle_oe: got %b want 0", miso_oe); else pass_cnt++;
    rx_ready = 1'b1;
    tick(1);
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_handshake: got rx_valid %b want 0", rx_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] g1, g2, v1, v2;
    int base, gap0;
    rx_ready = 1'b1;
    v1 = DW'($urandom);
    v2 = DW'($urandom);
    do_load(v1);
    base = got_q.size();
    gap0 = busy_gap;
    ss_on();
    in_burst = 1'b1;
    do_load(v2);           // lands after frame 1 started, so frame 2 sends it
    xfer(8'h81, 8, g1);
    xfer(8'h7E, 8, g2);
    in_burst = 1'b0;
    ss_off();
    m_last_rx = 8'h7E;
    total_cnt++; if (g1 !== v1) $display("FAIL b2b_miso1: got %h want %h", g1, v1); else pass_cnt++;
    total_cnt++; if (g2 !== v2) $display("FAIL b2b_miso2: got %h want %h", g2, v2); else pass_cnt++;
    total_cnt++; if (got_q.size() !== base + 2) $display("FAIL b2b_count: got %0d words want 2", got_q.size() - base); else pass_cnt++;
    total_cnt++; if (got_q[base] !== 8'h81) $display("FAIL b2b_word1: got %h want 81", got_q[base]); else pass_cnt++;
    total_cnt++; if (got_q[base+1] !== 8'h7E) $display("FAIL b2b_word2: got %h want 7e", got_q[base+1]); else pass_cnt++;
    total_cnt++; if (busy_gap !== gap0) $display("FAIL b2b_busy: got %0d idle cycles want 0", busy_gap - gap0); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] g;
    int e0, base;
    rx_ready = 1'b1;
    e0 = err_cnt;
    base = got_q.size();
    ss_on();
    xfer(8'hFF, 5, g);
    ss_off();
    total_cnt++; if (err_cnt !== e0 + 1) $display("FAIL ferr_pulses: got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ferr_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
    total_cnt++; if (got_q.size() !== base) $display("FAIL ferr_no_word: got %0d words want 0", got_q.size() - base); else pass_cnt++;
    total_cnt++; if (rx_data !== m_last_rx) $display("FAIL ferr_rx_data: got %h want %h", rx_data, m_last_rx); else pass_cnt++;
    total_cnt++; if (miso_oe !== 1'b0) $display("FAIL ferr_miso_oe: got %b want 0", miso_oe); else pass_cnt++;
    total_cnt++; if (state_dbg !== 2'd0) $display("FAIL ferr_state: got %0d want 0", state_dbg); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] g;
    rx_ready = 1'b0;
    ss_on(); xfer(8'h11, 8, g); ss_off();
    ss_on(); xfer(8'h22, 8, g); ss_off();
    m_last_rx = 8'h22;
    total_cnt++; if (rx_data !== 8'h22) $display("FAIL ovr_rx_data: got %h want 22", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_rx_valid: got %b want 1", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
    total_cnt++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag_set: got %b want 1", rx_overrun); else pass_cnt++;
`endif
    rx_ready = 1'b1;
    tick(2);
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_accept: got rx_valid %b want 0", rx_valid); else pass_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
    total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL ovr_flag_clear: got %b want 0", rx_overrun); else pass_cnt++;
`endif
  endtask

  task automatic test_load_collision();
    logic [DW-1:0] g1, g2, old_hold;
    rx_ready = 1'b1;
    do_load(8'hC3);
    old_hold = m_hold;
    ss = 1'b1;
    tick(2);               // next edge is the one where ss is seen high
    tx_data = 8'h5A;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    m_hold = 8'h5A;
    total_cnt++; if (tx_empty !== 1'b0) $display("FAIL coll_tx_empty: got %b want 0", tx_empty); else pass_cnt++;
    xfer(DW'($urandom), 8, g1);
    xfer(DW'($urandom), 8, g2);
    ss_off();
    total_cnt++; if (g1 !== old_hold) $display("FAIL coll_first: got %h want %h", g1, old_hold); else pass_cnt++;
    total_cnt++; if (g2 !== m_hold) $display("FAIL coll_second: got %h want %h", g2, m_hold); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL coll_consumed: got %b want 1", tx_empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] g;
    int e0;
    rx_ready = 1'b0;
    do_load(DW'($urandom));
    e0 = err_cnt;
    ss_on();
    xfer(8'hF0, 4, g);
    tick(1);
    reset = 1'b1;
    #1;
    total_cnt++; if ({miso, miso_oe, busy, frame_err, rx_valid} !== 5'b0) $display("FAIL rst_mid_outs: got %b want 00000", {miso, miso_oe, busy, frame_err, rx_valid}); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL rst_mid_tx_empty: got %b want 1", tx_empty); else pass_cnt++;
    ss = 1'b0; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    reset = 1'b0;
    m_hold = '0;
    tick(2);
    ss_on();
    xfer(8'h96, 8, g);
    ss_off();
    m_last_rx = 8'h96;
    total_cnt++; if (rx_data !== 8'h96) $display("FAIL rst_mid_rx_after: got %h want 96", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b1) $display("FAIL rst_mid_valid_after: got %b want 1", rx_valid); else pass_cnt++;
    total_cnt++; if (g !== m_hold) $display("FAIL rst_mid_stale_tx: got %h want %h", g, m_hold); else pass_cnt++;
    total_cnt++; if (err_cnt !== e0) $display("FAIL rst_mid_no_ferr: got %0d pulses want 0", err_cnt - e0); else pass_cnt++;
    rx_ready = 1'b1;
    tick(2);
  endtask

  task automatic test_random();
    logic [DW-1:0] g, w, v;
    logic [DW-1:0] sent_q[$];
    int nf, base;
    rx_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      nf = $urandom_range(1, 3);
      v = DW'($urandom);
      do_load(v);
      sent_q.delete();
      base = got_q.size();
      ss_on();
      for (int f = 0; f < nf; f++) begin
        w = DW'($urandom);
        sent_q.push_back(w);
        xfer(w, 8, g);
        total_cnt++; if (g !== m_hold) $display("FAIL rand_miso it%0d f%0d: got %h want %h", it, f, g, m_hold); else pass_cnt++;
      end
      ss_off();
      total_cnt++; if (got_q.size() !== base + nf) $display("FAIL rand_count it%0d: got %0d want %0d", it, got_q.size() - base, nf); else pass_cnt++;
      for (int f = 0; f < nf; f++) begin
        total_cnt++; if (got_q[base+f] !== sent_q[f]) $display("FAIL rand_rx it%0d f%0d: got %h want %h", it, f, got_q[base+f], sent_q[f]); else pass_cnt++;
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_load_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
